// File: rtl/imem_boot_ctrl_pkg.sv
// rtl/imem_boot_ctrl_pkg.sv - shared types and constants for the instruction-memory boot controller
package imem_boot_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_READY = 3'd1,
    ST_RUN   = 3'd2,
    ST_HALT  = 3'd3
  } state_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int          DEF_ADDR_W = 4;
  localparam int          DEF_DEPTH  = 16;
  localparam int          RUN_CNT_W  = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter with synchronous clear that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/imem_boot_ctrl.sv
// rtl/imem_boot_ctrl.sv - load/run/halt sequencer sharing the instruction-memory port between loader and CPU fetch
// Optional PC bounds checking against the loaded length: IMEM_BOUNDS_CHECK_EN
module imem_boot_ctrl
  import imem_boot_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic                 ld_last,
  input  logic                 start,
  input  logic                 halt_req,
  input  logic                 reload,
  input  logic [31:0]          pc,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic [DATA_W-1:0]    imem_wdata,
  output logic                 imem_we,
  input  logic [DATA_W-1:0]    imem_rdata,
  output logic [DATA_W-1:0]    instr,
  output logic                 cpu_rst,
  output logic                 cpu_run,
  output logic [ADDR_W:0]      prog_len,
  output logic [RUN_CNT_W-1:0] run_cycles,
  output logic                 fetch_err,
  output logic [2:0]           state
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_e            state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   prog_len_q;
  logic [ADDR_W:0]   prog_len_inc;
  logic              start_pend_q;
  logic              fetch_err_q;
  logic              cpu_rst_q;
  logic              cpu_run_q;
  logic              in_run;
  logic              accept;
  logic              oob;
  logic              run_clr;

  assign in_run       = (state_q == ST_RUN);
  assign ld_ready     = (state_q == ST_LOAD);
  assign accept       = ld_valid && ld_ready;
  assign prog_len_inc = prog_len_q + (ADDR_W+1)'(1);

`ifdef IMEM_BOUNDS_CHECK_EN
  assign oob = in_run && (pc >= {{(31-ADDR_W){1'b0}}, prog_len_q});
`else
  // Without bounds checking the upper PC bits are dropped, so fetches wrap modulo DEPTH.
  logic unused_pc_hi;
  assign unused_pc_hi = ^pc[31:ADDR_W];
  assign oob          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      wr_ptr_q     <= '0;
      prog_len_q   <= '0;
      start_pend_q <= 1'b0;
      fetch_err_q  <= 1'b0;
      cpu_rst_q    <= 1'b1;
      cpu_run_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (start) start_pend_q <= 1'b1;
          if (accept) begin
            wr_ptr_q   <= wr_ptr_q + ADDR_W'(1);
            prog_len_q <= prog_len_inc;
            if (ld_last || (prog_len_inc == DEPTH_L)) state_q <= ST_READY;
          end
        end
        ST_READY: begin
          if (reload) begin
            state_q      <= ST_LOAD;
            prog_len_q   <= '0;
            wr_ptr_q     <= '0;
            start_pend_q <= 1'b0;
          end else if (start || start_pend_q) begin
            state_q      <= ST_RUN;
            start_pend_q <= 1'b0;
            cpu_rst_q    <= 1'b0;
            cpu_run_q    <= 1'b1;
          end
        end
        ST_RUN: begin
          // An explicit halt wins, so a simultaneous bad fetch is not flagged.
          if (halt_req || oob) begin
            state_q   <= ST_HALT;
            cpu_run_q <= 1'b0;
            if (!halt_req) fetch_err_q <= 1'b1;
          end
        end
        ST_HALT: begin
          if (reload) begin
            state_q     <= ST_LOAD;
            prog_len_q  <= '0;
            wr_ptr_q    <= '0;
            fetch_err_q <= 1'b0;
            cpu_rst_q   <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_LOAD;
          cpu_rst_q <= 1'b1;
          cpu_run_q <= 1'b0;
        end
      endcase
    end
  end

  assign run_clr = (state_q == ST_HALT) && reload;

  sat_counter #(
    .W(RUN_CNT_W)
  ) u_run_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (in_run),
    .clr_i  (run_clr),
    .count_o(run_cycles)
  );

  assign imem_addr  = in_run ? pc[ADDR_W-1:0] : wr_ptr_q;
  assign imem_wdata = ld_data;
  assign imem_we    = accept;
  assign instr      = (in_run && !oob) ? imem_rdata : DATA_W'(NOP_INSTR);
  assign cpu_rst    = cpu_rst_q;
  assign cpu_run    = cpu_run_q;
  assign prog_len   = prog_len_q;
  assign fetch_err  = fetch_err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb/tb_imem_boot_ctrl.sv - self-checking bench for imem_boot_ctrl with a word-array program model
module tb_imem_boot_ctrl;

  localparam int AW  = 4;
  localparam int DEP = 16;
  localparam int DW  = 32;

  logic          clk = 1'b0;
  logic          rst, ld_valid, ld_ready, ld_last, start, halt_req, reload;
  logic          imem_we, cpu_rst, cpu_run, fetch_err;
  logic [DW-1:0] ld_data, imem_wdata, imem_rdata, instr;
  logic [31:0]   pc;
  logic [AW-1:0] imem_addr;
  logic [AW:0]   prog_len;
  logic [15:0]   run_cycles;
  logic [2:0]    state;

  logic [DW-1:0] tb_mem  [DEP];
  logic [DW-1:0] ref_mem [DEP];

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int exp_len  = 0;
  int exp_run  = 0;

  imem_boot_ctrl #(.ADDR_W(AW), .DEPTH(DEP), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_last(ld_last), .start(start), .halt_req(halt_req), .reload(reload), .pc(pc),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_we(imem_we), .imem_rdata(imem_rdata),
    .instr(instr), .cpu_rst(cpu_rst), .cpu_run(cpu_run), .prog_len(prog_len),
    .run_cycles(run_cycles), .fetch_err(fetch_err), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_we) tb_mem[imem_addr] <= imem_wdata;
  assign imem_rdata = tb_mem[imem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0; start = 1'b0;
    halt_req = 1'b0; reload = 1'b0; pc = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_len = 0;
    exp_run = 0;
  endtask

  // Streams n words; the model keeps the first DEP words in program order.
  task automatic load_prog(input int n, input bit with_last, input int start_at);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = $urandom;
      ld_last  = with_last && (i == n - 1);
      start    = (i == start_at);
      if (exp_len < DEP) begin
        ref_mem[exp_len] = ld_data;
        exp_len++;
      end
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tot_cnt++; if (state !== 3'd0) $display("FAIL rst_state got %0d exp 0", state); else pass_cnt++;
    tot_cnt++; if (prog_len !== 5'd0) $display("FAIL rst_prog_len got %0d exp 0", prog_len); else pass_cnt++;
    tot_cnt++; if ({cpu_rst, cpu_run} !== 2'b10) $display("FAIL rst_cpu got rst=%0b run=%0b exp rst=1 run=0", cpu_rst, cpu_run); else pass_cnt++;
    tot_cnt++; if (run_cycles !== 16'd0) $display("FAIL rst_run_cycles got %0d exp 0", run_cycles); else pass_cnt++;
    tot_cnt++; if (fetch_err !== 1'b0) $display("FAIL rst_fetch_err got %0b exp 0", fetch_err); else pass_cnt++;
    tot_cnt++; if ({ld_ready, imem_we} !== 2'b10) $display("FAIL rst_ld got ready=%0b we=%0b exp ready=1 we=0", ld_ready, imem_we); else pass_cnt++;
    tot_cnt++; if (instr !== 32'h0) $display("FAIL rst_instr got %h exp 0", instr); else pass_cnt++;
  endtask

  task automatic test_load_run();
    int bad;
    do_reset();
    load_prog(3, 1'b1, -1);
    tot_cnt++; if (state !== 3'd1) $display("FAIL lr_state got %0d exp 1", state); else pass_cnt++;
    tot_cnt++; if (prog_len !== 5'(exp_len)) $display("FAIL lr_prog_len got %0d exp %0d", prog_len, exp_len); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 3; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
    tot_cnt++; if (bad != 0) $display("FAIL lr_mem got %0d bad words exp 0", bad); else pass_cnt++;
    ld_valid = 1'b1; ld_data = $urandom;
    #1;
    tot_cnt++; if ({ld_ready, imem_we} !== 2'b00) $display("FAIL lr_ready_ignore got ready=%0b we=%0b exp 0 0", ld_ready, imem_we); else pass_cnt++;
    ld_valid = 1'b0; start = 1'b1; pc = 32'd0;
    tick();
    start = 1'b0;
    tot_cnt++; if ({state, cpu_run, cpu_rst} !== {3'd2, 2'b10}) $display("FAIL lr_run got state=%0d run=%0b rst=%0b exp 2 1 0", state, cpu_run, cpu_rst); else pass_cnt++;
    tot_cnt++; if (instr !== ref_mem[0]) $display("FAIL lr_instr0 got %h exp %h", instr, ref_mem[0]); else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      int a;
      a = $urandom_range(0, 2);
`ifdef IMEM_BOUNDS_CHECK_EN
      pc = 32'(a);
`else
      pc = 32'(a + 16 * $urandom_range(0, 3));
`endif
      #1;
      tot_cnt++; if (instr !== ref_mem[a]) $display("FAIL lr_fetch pc=%0d got %h exp %h", pc, instr, ref_mem[a]); else pass_cnt++;
      tick();
      exp_run++;
    end
    tot_cnt++; if (run_cycles !== 16'(exp_run)) $display("FAIL lr_run_cycles got %0d exp %0d", run_cycles, exp_run); else pass_cnt++;
  endtask

  task automatic test_start_pend();
    do_reset();
    load_prog(4, 1'b1, 1);
    tot_cnt++; if (state !== 3'd1) $display("FAIL sp_ready got %0d exp 1", state); else pass_cnt++;
    tick();
    tot_cnt++; if ({state, cpu_run} !== {3'd2, 1'b1}) $display("FAIL sp_run got state=%0d run=%0b exp 2 1", state, cpu_run); else pass_cnt++;
  endtask

  task automatic test_overflow();
    int accepted;
    int bad;
    do_reset();
    accepted = 0;
    for (int i = 0; i < DEP + 1; i++) begin
      ld_valid = 1'b1; ld_last = 1'b0; ld_data = $urandom;
      if (exp_len < DEP) begin
        ref_mem[exp_len] = ld_data;
        exp_len++;
      end
      if (i == DEP) begin
        tot_cnt++; if (ld_ready !== 1'b0) $display("FAIL ov_ready17 got %0b exp 0", ld_ready); else pass_cnt++;
      end
      if (ld_ready) accepted++;
      tick();
    end
    ld_valid = 1'b0;
    tot_cnt++; if (accepted != DEP) $display("FAIL ov_accepted got %0d exp %0d", accepted, DEP); else pass_cnt++;
    tot_cnt++; if ({state, prog_len} !== {3'd1, 5'(exp_len)}) $display("FAIL ov_done got state=%0d len=%0d exp 1 %0d", state, prog_len, exp_len); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < DEP; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
    tot_cnt++; if (bad != 0) $display("FAIL ov_mem got %0d bad words exp 0", bad); else pass_cnt++;
  endtask

  task automatic test_bounds();
    do_reset();
    load_prog(2, 1'b1, -1);
    start = 1'b1; pc = 32'd0;
    tick();
    start = 1'b0;
`ifdef IMEM_BOUNDS_CHECK_EN
    pc = 32'd1;
    #1;
    tot_cnt++; if (instr !== ref_mem[1]) $display("FAIL bc_inrange got %h exp %h", instr, ref_mem[1]); else pass_cnt++;
    pc = 32'd2;
    #1;
    tot_cnt++; if (instr !== 32'h0) $display("FAIL bc_nop got %h exp 0", instr); else pass_cnt++;
    tick();
    pc = 32'd0;
    tot_cnt++; if ({fetch_err, state, cpu_run} !== {1'b1, 3'd3, 1'b0}) $display("FAIL bc_halt got err=%0b state=%0d run=%0b exp 1 3 0", fetch_err, state, cpu_run); else pass_cnt++;
`else
    pc = 32'd18;
    #1;
    tot_cnt++; if (imem_addr !== 4'd2) $display("FAIL wrap_addr got %0d exp 2", imem_addr); else pass_cnt++;
    tot_cnt++; if (instr !== ref_mem[2]) $display("FAIL wrap_instr got %h exp %h", instr, ref_mem[2]); else pass_cnt++;
    tick();
    pc = 32'd0;
    tot_cnt++; if ({fetch_err, state} !== {1'b0, 3'd2}) $display("FAIL wrap_state got err=%0b state=%0d exp 0 2", fetch_err, state); else pass_cnt++;
`endif
  endtask

  task automatic test_halt_reload();
    do_reset();
    load_prog(3, 1'b1, -1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pc = 32'($urandom_range(0, 2));
      tick();
      exp_run++;
    end
    halt_req = 1'b1; start = 1'b1;
    tick();
    exp_run++;
    halt_req = 1'b0;
    tot_cnt++; if ({state, cpu_run, cpu_rst} !== {3'd3, 2'b00}) $display("FAIL hr_halt got state=%0d run=%0b rst=%0b exp 3 0 0", state, cpu_run, cpu_rst); else pass_cnt++;
    tot_cnt++; if (run_cycles !== 16'(exp_run)) $display("FAIL hr_run_cycles got %0d exp %0d", run_cycles, exp_run); else pass_cnt++;
    tick();
    start = 1'b0;
    tot_cnt++; if ({state, run_cycles} !== {3'd3, 16'(exp_run)}) $display("FAIL hr_start_ignored got state=%0d cycles=%0d exp 3 %0d", state, run_cycles, exp_run); else pass_cnt++;
    reload = 1'b1;
    tick();
    reload = 1'b0;
    exp_len = 0; exp_run = 0;
    tot_cnt++; if ({state, prog_len, cpu_rst} !== {3'd0, 5'd0, 1'b1}) $display("FAIL hr_reload got state=%0d len=%0d rst=%0b exp 0 0 1", state, prog_len, cpu_rst); else pass_cnt++;
    tot_cnt++; if ({run_cycles, ld_ready} !== {16'd0, 1'b1}) $display("FAIL hr_reload_cnt got cycles=%0d ready=%0b exp 0 1", run_cycles, ld_ready); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int it = 0; it < 4; it++) begin
      int n;
      n = (it == 0) ? 1 : $urandom_range(1, DEP);
      load_prog(n, 1'b1, -1);
      tot_cnt++; if ({state, prog_len} !== {3'd1, 5'(n)}) $display("FAIL b2b_len got state=%0d len=%0d exp 1 %0d", state, prog_len, n); else pass_cnt++;
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_run = 0;
      for (int k = 0; k < 3; k++) begin
        int a;
        a = $urandom_range(0, n - 1);
        pc = 32'(a);
        #1;
        tot_cnt++; if (instr !== ref_mem[a]) $display("FAIL b2b_fetch pc=%0d got %h exp %h", a, instr, ref_mem[a]); else pass_cnt++;
        tick();
        exp_run++;
      end
      halt_req = 1'b1;
      tick();
      exp_run++;
      halt_req = 1'b0;
      tot_cnt++; if ({state, run_cycles} !== {3'd3, 16'(exp_run)}) $display("FAIL b2b_halt got state=%0d cycles=%0d exp 3 %0d", state, run_cycles, exp_run); else pass_cnt++;
      reload = 1'b1;
      tick();
      reload = 1'b0;
      exp_len = 0;
    end
  endtask

  task automatic test_rst_in_run();
    do_reset();
    load_prog(2, 1'b1, -1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tot_cnt++; if ({state, cpu_rst, cpu_run} !== {3'd0, 2'b10}) $display("FAIL rr_state got state=%0d rst=%0b run=%0b exp 0 1 0", state, cpu_rst, cpu_run); else pass_cnt++;
    tot_cnt++; if ({prog_len, run_cycles, fetch_err} !== {5'd0, 16'd0, 1'b0}) $display("FAIL rr_regs got len=%0d cycles=%0d err=%0b exp 0 0 0", prog_len, run_cycles, fetch_err); else pass_cnt++;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_load_run();
    test_start_pend();
    test_overflow();
    test_bounds();
    test_halt_reload();
    test_back_to_back();
    test_rst_in_run();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
